// File: rtl/uart_boot_loader.sv
// UART 8N1 boot loader: receives a framed program image, writes it into imem, releases the CPU.
// Optional checksum byte after the image is enabled by defining BOOT_CHECKSUM_EN.
module uart_boot_loader #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned ADDR_W       = 10,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              uart_rx_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_hold_o,
    output logic              boot_done_o,
    output logic              boot_err_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        StSync, StLenLo, StLenHi, StData, StChk, StDone, StErr
    } state_e;
    localparam state_e StAfterData = StChk;
`else
    typedef enum logic [2:0] {
        StSync, StLenLo, StLenHi, StData, StDone, StErr
    } state_e;
    localparam state_e StAfterData = StDone;
`endif

    // ---------------- RX front end ----------------
    logic [1:0]      rx_sync_q;
    logic            rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            rx;
    logic            byte_valid;
    logic            frame_err;

    assign rx = rx_sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], uart_rx_i};
            rx_prev_q  <= rx;
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx) begin
                    rx_state_d = RxStart;
                    cnt_d      = '0;
                end
            end
            RxStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    rx_state_d = rx ? RxIdle : RxData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RxData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RxStop: begin
                if (cnt_q == BitLast) begin
                    byte_valid = rx;
                    frame_err  = !rx;
                    rx_state_d = RxIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ---------------- Frame FSM ----------------
    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [15:0]       len_new;
    logic              last_word;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    assign last_word = (32'(addr_q) == (32'(len_q) - 32'd1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StSync;
            len_q   <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
`ifdef BOOT_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        len_new = {shift_q, len_q[7:0]};
`ifdef BOOT_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        if (frame_err) begin
            state_d = StErr;
        end else if (byte_valid) begin
            case (state_q)
                StSync: begin
                    if (shift_q == SYNC_BYTE) state_d = StLenLo;
                end
                StLenLo: begin
                    len_d[7:0] = shift_q;
                    state_d    = StLenHi;
                end
                StLenHi: begin
                    len_d  = len_new;
                    addr_d = '0;
                    idx_d  = '0;
`ifdef BOOT_CHECKSUM_EN
                    chk_d  = '0;
`endif
                    if (32'(len_new) > (32'd1 << ADDR_W)) begin
                        state_d = StErr;
                    end else if (len_new == 16'd0) begin
                        state_d = StAfterData;
                    end else begin
                        state_d = StData;
                    end
                end
                StData: begin
                    word_d[8*idx_q +: 8] = shift_q;
                    idx_d = idx_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                    chk_d = chk_q ^ shift_q;
`endif
                    if (idx_q == 2'd3) begin
                        wdata_d = {shift_q, word_q[23:0]};
                        we_d    = 1'b1;
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                StChk: begin
                    state_d = (shift_q == chk_q) ? StDone : StErr;
                end
`endif
                StDone, StErr: begin
                    if (shift_q == SYNC_BYTE) state_d = StLenLo;
                end
                default: state_d = StSync;
            endcase
        end else if (we_q) begin
            // Strobe cycle: advance the address or leave DATA after the final word.
            if (last_word) begin
                state_d = StAfterData;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign boot_done_o  = (state_q == StDone);
    assign boot_err_o   = (state_q == StErr);
    assign cpu_hold_o   = (state_q != StDone);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: table of frames plus hand-written corner sequences.
module tb_uart_boot_loader;

    localparam int CPB    = 16;
    localparam int ADDR_W = 10;
`ifdef BOOT_CHECKSUM_EN
    localparam int C = 1;
`else
    localparam int C = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx = 1'b1;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              boot_done;
    logic              boot_err;

    always #5 clk = ~clk;

    uart_boot_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (ADDR_W),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .uart_rx_i   (rx),
        .imem_we_o   (imem_we),
        .imem_addr_o (imem_addr),
        .imem_wdata_o(imem_wdata),
        .cpu_hold_o  (cpu_hold),
        .boot_done_o (boot_done),
        .boot_err_o  (boot_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] wr_addr [64];
    logic [31:0]       wr_data [64];
    int                wr_cnt = 0;

    always @(negedge clk) begin
        if (imem_we && rst_n) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] <= imem_addr;
                wr_data[wr_cnt] <= imem_wdata;
            end
            wr_cnt <= wr_cnt + 1;
        end
    end

    typedef struct packed {
        logic        rst_first;
        logic [4:0]  n;
        logic [1:0]  nwr;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic        done;
        logic        err;
    } vec_t;

    vec_t       vecs [$];
    logic [7:0] stim [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic done, input logic err);
        check({tag, ".boot_done"}, 32'(boot_done), 32'(done));
        check({tag, ".boot_err"},  32'(boot_err),  32'(err));
        check({tag, ".cpu_hold"},  32'(cpu_hold),  32'(!done));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".imem_we"},    32'(imem_we),   32'd0);
        check({tag, ".imem_addr"},  32'(imem_addr), 32'd0);
        check({tag, ".imem_wdata"}, imem_wdata,     32'd0);
        check_status(tag, 1'b0, 1'b0);
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
        rx = 1'b1;
    endtask

    task automatic send_list(input logic [7:0] q [$]);
        foreach (q[i]) send_byte(q[i], 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int off;
        int base;
        logic [7:0] q [$];

        // Reset and idle hold
        rx = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check_reset_outputs("idle");

        // Frame table
        stim = {stim, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00};
`ifdef BOOT_CHECKSUM_EN
        stim.push_back(8'h90);
`endif
        vecs.push_back('{1'b1, 5'(11 + C), 2'd2, 32'h00000013, 32'h00100093, 1'b1, 1'b0});

        stim = {stim, 8'h55, 8'h12, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef BOOT_CHECKSUM_EN
        stim.push_back(8'h22);
`endif
        vecs.push_back('{1'b1, 5'(9 + C), 2'd1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0});

        // Reload from DONE with LEN one past the address space
        stim = {stim, 8'hA5, 8'h01, 8'h04};
        vecs.push_back('{1'b0, 5'd3, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1});

        // Reload from ERR with an empty image
        stim = {stim, 8'hA5, 8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
        stim.push_back(8'h00);
`endif
        vecs.push_back('{1'b0, 5'(3 + C), 2'd0, 32'h0, 32'h0, 1'b1, 1'b0});

        stim = {stim, 8'hA5, 8'hFF, 8'hFF};
        vecs.push_back('{1'b0, 5'd3, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1});

`ifdef BOOT_CHECKSUM_EN
        stim = {stim, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
        vecs.push_back('{1'b0, 5'd8, 2'd1, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1});
`endif

        off = 0;
        for (int v = 0; v < vecs.size(); v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            if (vecs[v].rst_first) do_reset();
            base = wr_cnt;
            for (int j = 0; j < int'(vecs[v].n); j++) send_byte(stim[off + j], 1'b1);
            off += int'(vecs[v].n);
            settle();
            check({tag, ".writes"}, 32'(wr_cnt - base), 32'(vecs[v].nwr));
            for (int k = 0; k < int'(vecs[v].nwr); k++) begin
                check($sformatf("%s.addr%0d", tag, k), 32'(wr_addr[base + k]), 32'(k));
                check($sformatf("%s.data%0d", tag, k), wr_data[base + k],
                      (k == 0) ? vecs[v].wd0 : vecs[v].wd1);
            end
            check_status(tag, vecs[v].done, vecs[v].err);
        end

        // Framing error on a DATA byte after one word has been written
        do_reset();
        base = wr_cnt;
        q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        send_list(q);
        send_byte(8'h93, 1'b0);
        for (int i = 0; i < 20; i++) bit_time(1'b1);
        q = '{8'h00, 8'h10, 8'h00};
        send_list(q);
        settle();
        check("frame.writes", 32'(wr_cnt - base), 32'd1);
        check("frame.data0", wr_data[base], 32'h00000013);
        check_status("frame", 1'b0, 1'b1);
        q = '{8'hA5, 8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
        q.push_back(8'h00);
`endif
        send_list(q);
        settle();
        check("frame_reload.writes", 32'(wr_cnt - base), 32'd1);
        check_status("frame_reload", 1'b1, 1'b0);

        // Quarter-bit glitch while waiting for LEN_LO must not produce a byte
        do_reset();
        base = wr_cnt;
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) bit_time(1'b1);
        rx = 1'b0;
        repeat (CPB / 4) @(posedge clk);
        #1 rx = 1'b1;
        for (int i = 0; i < 4; i++) bit_time(1'b1);
        check_status("glitch_wait", 1'b0, 1'b0);
        q = '{8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
        q.push_back(8'h00);
`endif
        send_list(q);
        settle();
        check("glitch.writes", 32'(wr_cnt - base), 32'd0);
        check_status("glitch", 1'b1, 1'b0);

        // Reset in the middle of a 4-word image, then a fresh load from address 0
        do_reset();
        base = wr_cnt;
        q = '{8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'hEF, 8'hBE};
        send_list(q);
        settle();
        check("midrst.writes_before", 32'(wr_cnt - base), 32'd2);
        check("midrst.addr_before", 32'(imem_addr), 32'd2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("midrst_async");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        base = wr_cnt;
        q = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef BOOT_CHECKSUM_EN
        q.push_back(8'h08);
`endif
        send_list(q);
        settle();
        check("midrst.writes_after", 32'(wr_cnt - base), 32'd1);
        check("midrst.addr0", 32'(wr_addr[base]), 32'd0);
        check("midrst.data0", wr_data[base], 32'h12345678);
        check_status("midrst", 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
